proc_dpath_imul_iter: RTL and testbench

Iterative shift-add integer multiplier for the X stage, next to the single-cycle ALU. Implements RISC-V MUL: the low p_nbits of in0*in1, identical for signed and unsigned operands. Consumes operand pairs from the D/X boundary over a val/rdy stream. Produces the product toward the X/M boundary over a val/rdy stream. Latency is variable, with early termination once the remaining multiplier bits are zero.

---
 rtl/proc_imul_pkg.sv | 27 ++
 rtl/proc_dpath_imul_iter_dpath.sv | 67 ++++++
 rtl/proc_dpath_imul_iter.sv | 82 ++++++++
 tb/tb_proc_dpath_imul_iter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/proc_imul_pkg.sv
// Shared types for the iterative multiplier: control FSM states and the
// datapath mux selects driven by the control unit.
package proc_imul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    A_LOAD  = 1'b0,
    A_SHIFT = 1'b1
  } a_mux_sel_t;

  typedef enum logic {
    B_LOAD  = 1'b0,
    B_SHIFT = 1'b1
  } b_mux_sel_t;

  typedef enum logic [1:0] {
    RES_CLEAR = 2'd0,
    RES_ADD   = 2'd1,
    RES_HOLD  = 2'd2
  } result_mux_sel_t;

endpackage

// File: rtl/proc_dpath_imul_iter_dpath.sv
// Shift-add datapath: multiplicand/multiplier/result registers, adder,
// shifters and iteration counter; reports early-exit conditions to control.
module proc_dpath_imul_iter_dpath
  import proc_imul_pkg::*;
#(
  parameter int unsigned p_nbits = 32,
  parameter int unsigned p_cbits = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*p_nbits-1:0]   istream_msg,
  input  a_mux_sel_t             a_mux_sel,
  input  b_mux_sel_t             b_mux_sel,
  input  result_mux_sel_t        result_mux_sel,
  input  logic                   reg_en,
  output logic                   b_is_zero_next,
  output logic                   count_done,
  output logic [p_nbits-1:0]     result
);

  logic [p_nbits-1:0] a_q, a_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] result_q, result_d;
  logic [p_cbits-1:0] counter_q, counter_d;
  logic [p_cbits-1:0] counter_inc;

  assign counter_inc    = counter_q + 1'b1;
  assign b_is_zero_next = (b_q[p_nbits-1:1] == '0);
  assign count_done     = (counter_inc == p_cbits'(p_nbits));
  assign result         = result_q;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    counter_d = counter_q;
    if (reg_en) begin
      a_d       = (a_mux_sel == A_LOAD) ? istream_msg[2*p_nbits-1:p_nbits] : (a_q << 1);
      b_d       = (b_mux_sel == B_LOAD) ? istream_msg[p_nbits-1:0] : (b_q >> 1);
      // The counter restarts with the operand load and advances with each shift.
      counter_d = (b_mux_sel == B_LOAD) ? '0 : counter_inc;
    end
  end

  always_comb begin
    result_d = result_q;
    case (result_mux_sel)
      RES_CLEAR: result_d = '0;
      RES_ADD:   result_d = b_q[0] ? (result_q + a_q) : result_q;
      default:   result_d = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      counter_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      counter_q <= counter_d;
    end
  end

endmodule

// File: rtl/proc_dpath_imul_iter.sv
// Iterative shift-add multiplier (low p_nbits of in0*in1) with val/rdy
// streams; control FSM here, registers and arithmetic in the dpath.
module proc_dpath_imul_iter #(
  parameter int unsigned p_nbits = 32,
  parameter int unsigned p_cbits = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits-1:0] istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [p_nbits-1:0]   ostream_msg
);

  import proc_imul_pkg::*;

  state_t          state_q, state_d;
  a_mux_sel_t      a_mux_sel;
  b_mux_sel_t      b_mux_sel;
  result_mux_sel_t result_mux_sel;
  logic            reg_en;
  logic            b_is_zero_next;
  logic            count_done;
  logic            in_fire;

  // Handshake outputs are decoded from the state flop, forced low under reset.
  assign istream_rdy = (state_q == IDLE) && !reset;
  assign ostream_val = (state_q == DONE) && !reset;
  assign in_fire     = istream_val && istream_rdy;

  always_comb begin
    state_d        = state_q;
    a_mux_sel      = A_SHIFT;
    b_mux_sel      = B_SHIFT;
    result_mux_sel = RES_HOLD;
    reg_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d        = CALC;
          a_mux_sel      = A_LOAD;
          b_mux_sel      = B_LOAD;
          result_mux_sel = RES_CLEAR;
          reg_en         = 1'b1;
        end
      end
      CALC: begin
        reg_en         = 1'b1;
        result_mux_sel = RES_ADD;
        if (b_is_zero_next || count_done) state_d = DONE;
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  proc_dpath_imul_iter_dpath #(
    .p_nbits (p_nbits),
    .p_cbits (p_cbits)
  ) u_dpath (
    .clk            (clk),
    .reset          (reset),
    .istream_msg    (istream_msg),
    .a_mux_sel      (a_mux_sel),
    .b_mux_sel      (b_mux_sel),
    .result_mux_sel (result_mux_sel),
    .reg_en         (reg_en),
    .b_is_zero_next (b_is_zero_next),
    .count_done     (count_done),
    .result         (ostream_msg)
  );

endmodule

// File: tb/tb_proc_dpath_imul_iter.sv
// Bench for proc_dpath_imul_iter: directed and randomized operand pairs
// checked against an arithmetic product/latency model.
module tb_proc_dpath_imul_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [63:0] istream_msg;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_msg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  proc_dpath_imul_iter #(
    .p_nbits (32),
    .p_cbits (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .istream_msg (istream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .ostream_msg (ostream_msg)
  );

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  // Cycles from accept to first ostream_val: k+1, k = index of top set bit + 1 (min 1).
  function automatic int ref_lat(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k + 1;
  endfunction

  // Runs one operation; stall = cycles ostream_rdy stays low after val rises.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                        output logic [31:0] prod, output int lat, output bit timeout,
                        output bit held_ok, output bit post_ok);
    int w;
    logic [31:0] first;
    timeout = 0; held_ok = 1; post_ok = 1; lat = 0; prod = '0;
    ostream_rdy = (stall == 0);
    w = 0;
    while (istream_rdy !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) begin timeout = 1; return; end
    istream_val = 1'b1;
    istream_msg = {a, b};
    @(negedge clk);
    istream_val = 1'b0;
    istream_msg = $urandom();
    lat = 1;
    while (ostream_val !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) begin timeout = 1; return; end
    prod  = ostream_msg;
    first = ostream_msg;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (ostream_msg !== first || ostream_val !== 1'b1 || istream_rdy !== 1'b0) held_ok = 0;
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) post_ok = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; istream_val = 1'b0; istream_msg = '0; ostream_rdy = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (istream_rdy !== 1'b0 || ostream_val !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: rdy=%b val=%b required rdy=0 val=0", istream_rdy, ostream_val);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0 || ostream_msg !== 32'd0) begin
      fails++;
      $display("FAIL reset_release: rdy=%b val=%b msg=%h required rdy=1 val=0 msg=0",
               istream_rdy, ostream_val, ostream_msg);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int stall);
    logic [31:0] prod;
    int lat;
    bit to, held, post;
    run_op(a, b, stall, prod, lat, to, held, post);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL %s_timeout: a=%h b=%h no handshake within bound", name, a, b);
      return;
    end
    if (prod !== ref_prod(a, b)) begin
      fails++;
      $display("FAIL %s_prod: a=%h b=%h got %h required %h", name, a, b, prod, ref_prod(a, b));
    end
    tests++;
    if (lat != ref_lat(b)) begin
      fails++;
      $display("FAIL %s_lat: a=%h b=%h got %0d required %0d", name, a, b, lat, ref_lat(b));
    end
    tests++;
    if (!held || !post) begin
      fails++;
      $display("FAIL %s_handshake: held_ok=%b post_ok=%b required 1 1", name, held, post);
    end
  endtask

  task automatic test_directed;
    check_op("mul_3x4", 32'd3, 32'd4, 0);
    check_op("mul_by_zero", 32'h12345678, 32'd0, 0);
    check_op("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    check_op("mul_neg", 32'hFFFFFFFE, 32'd3, 0);
  endtask

  task automatic test_back_to_back;
    check_op("bp_7x6", 32'd7, 32'd6, 5);
    check_op("b2b_5x5", 32'd5, 32'd5, 0);
  endtask

  task automatic test_reset_mid;
    istream_val = 1'b1;
    istream_msg = {32'h0000FFFF, 32'h0000FFFF};
    @(negedge clk);
    istream_val = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (istream_rdy !== 1'b0 || ostream_val !== 1'b0) begin
      fails++;
      $display("FAIL midreset_hold: rdy=%b val=%b required 0 0", istream_rdy, ostream_val);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
      fails++;
      $display("FAIL midreset_release: rdy=%b val=%b required 1 0", istream_rdy, ostream_val);
    end
    check_op("after_reset_2x9", 32'd2, 32'd9, 0);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      a = $urandom();
      b = $urandom() >> $urandom_range(0, 31);
      check_op("rand", a, b, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
